seq_det_ctrl: RTL and testbench

Programmable serial pattern-detection controller. Accepts parallel words over a valid/ready handshake and serializes them MSB-first into a configurable pattern matcher (pattern and length set through a config port). It counts matches and signals completion when a programmed hit threshold is reached. It sits between a word-oriented producer and the serial sequence-detection datapath, sequencing and configuring it.

---
 rtl/seq_det_ctrl_pkg.sv | 27 ++
 rtl/seq_det_match.sv | 64 ++++++
 rtl/seq_det_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared types, defaults and helpers for the seq_det_ctrl serial pattern detector.
// Optional feature macro used by this slice: SEQ_DET_CTRL_NO_OVERLAP_EN.
package seq_det_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PAT_W_DEF  = 7;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A length of zero or one beyond the history depth means "use the full depth".
    function automatic int clamp_len(input int len, input int pat_w);
        int r;
        if ((len == 0) || (len > pat_w)) begin
            r = pat_w;
        end else begin
            r = len;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Serial matcher: history shift register, saturating seen-count and masked compare.
// With SEQ_DET_CTRL_NO_OVERLAP_EN defined, a match restarts the history (non-overlapping hits).
module seq_det_match
    import seq_det_ctrl_pkg::*;
#(
    parameter  int PAT_W = PAT_W_DEF,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    logic [PAT_W-1:0] hist_q, hist_d, hist_next_s, mask_s;
    logic [LEN_W-1:0] seen_q, seen_d, seen_next_s;

    // Compare against the history as it will look after this bit is shifted in.
    always_comb begin
        hist_next_s = {hist_q[PAT_W-2:0], bit_in};
        seen_next_s = (seen_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : (seen_q + LEN_W'(1));
        for (int i = 0; i < PAT_W; i++) begin
            mask_s[i] = (i < int'(len));
        end
        match  = shift_en && (((hist_next_s ^ pattern) & mask_s) == '0) && (seen_next_s >= len);
        hist_d = hist_q;
        seen_d = seen_q;
        if (clear) begin
            hist_d = '0;
            seen_d = '0;
        end else if (shift_en) begin
`ifdef SEQ_DET_CTRL_NO_OVERLAP_EN
            if (match) begin
                hist_d = '0;
                seen_d = '0;
            end else begin
                hist_d = hist_next_s;
                seen_d = seen_next_s;
            end
`else
            hist_d = hist_next_s;
            seen_d = seen_next_s;
`endif
        end else begin
            hist_d = hist_q;
        end
    end

    // History and seen-count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-serial pattern detection controller: handshake, MSB-first serializer, config, hit counter.
// Build option SEQ_DET_CTRL_NO_OVERLAP_EN selects non-overlapping matching in seq_det_match.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int PAT_W  = PAT_W_DEF,
    parameter  int CNT_W  = CNT_W_DEF,
    localparam int LEN_W  = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              hit,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d, cnt_q, cnt_d, cnt_inc_s;
    logic              hit_q, hit_d, in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
    logic              clear_s, shift_en_s, bit_s, match_s;

    // Kept outside the FSM comb block so the matcher's compare never loops back through it.
    assign shift_en_s = (state_q == SHIFT) && !abort;
    assign clear_s    = start && !abort && ((state_q == IDLE) || (state_q == DONE));
    assign bit_s      = word_q[idx_q];

    seq_det_match #(.PAT_W(PAT_W)) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .shift_en (shift_en_s),
        .bit_in   (bit_s),
        .pattern  (pat_q),
        .len      (len_q),
        .match    (match_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        len_d     = len_q;
        thresh_d  = thresh_q;
        cnt_d     = cnt_q;
        hit_d     = 1'b0;
        cnt_inc_s = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d    = cfg_pattern;
                    len_d    = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
                    thresh_d = cfg_thresh;
                end else begin
                    pat_d = pat_q;
                end
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = IDX_W'(DATA_W - 1);
                    state_d = SHIFT;
                end else begin
                    state_d = WAIT;
                end
            end
            SHIFT: begin
                if (match_s) begin
                    hit_d = 1'b1;
                    cnt_d = cnt_inc_s;
                end else begin
                    hit_d = 1'b0;
                end
                // Reaching the threshold drops the rest of the current word.
                if (match_s && (thresh_q != '0) && (cnt_inc_s == thresh_q)) begin
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            hit_d   = 1'b0;
            cnt_d   = cnt_q;
        end else begin
            hit_d = hit_d;
        end
        in_ready_d = (state_d == WAIT);
        busy_d     = (state_d == WAIT) || (state_d == SHIFT);
        done_d     = (state_d == DONE);
    end

    // Controller state, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            pat_q      <= '1;
            len_q      <= LEN_W'(PAT_W);
            thresh_q   <= '0;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            thresh_q   <= thresh_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign hit      = hit_q;
    assign hit_cnt  = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: bit-stream reference model, directed cases, random traffic.
// Honours SEQ_DET_CTRL_NO_OVERLAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

    localparam int PAT_W = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cfg_we = 1'b0;
    logic [6:0] cfg_pattern = 7'd0;
    logic [2:0] cfg_len = 3'd0;
    logic [7:0] cfg_thresh = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, hit, busy, done;
    logic [7:0] hit_cnt;

    int checks = 0;
    int errors = 0;
    int hits_seen = 0;

    // Reference model: mode 0 idle, 1 wait, 2 shift, 3 done; stream holds the run's recent bits.
    int m_state, m_pat, m_len, m_thresh, m_cnt, m_hit;
    int stream[$];
    int bits[$];

    seq_det_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .hit(hit),
        .hit_cnt(hit_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_pat = 127; m_len = PAT_W; m_thresh = 0; m_cnt = 0; m_hit = 0;
        stream.delete();
        bits.delete();
    endtask

    task automatic model_latch();
        m_pat    = int'(cfg_pattern);
        m_len    = ((cfg_len == 3'd0) || (int'(cfg_len) > PAT_W)) ? PAT_W : int'(cfg_len);
        m_thresh = int'(cfg_thresh);
    endtask

    function automatic bit tail_matches();
        if (stream.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (stream[stream.size() - 1 - k] != ((m_pat >> k) & 1)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int nh;
        nh = 0;
        if (abort) begin
            if ((m_state == 0) && cfg_we) model_latch();
            m_state = 0;
            m_hit = 0;
            return;
        end
        case (m_state)
            0: begin
                if (cfg_we) model_latch();
                if (start) begin m_state = 1; m_cnt = 0; stream.delete(); end
            end
            1: begin
                if (in_valid) begin
                    bits.delete();
                    for (int i = 7; i >= 0; i--) bits.push_back(int'(in_data[i]));
                    m_state = 2;
                end
            end
            2: begin
                stream.push_back(bits.pop_front());
                if (tail_matches()) begin
                    nh = 1;
                    if (m_cnt < 255) m_cnt++;
`ifdef SEQ_DET_CTRL_NO_OVERLAP_EN
                    stream.delete();
`endif
                end
                if (stream.size() > PAT_W) void'(stream.pop_front());
                if ((nh == 1) && (m_thresh != 0) && (m_cnt == m_thresh)) begin
                    m_state = 3;
                    bits.delete();
                end else if (bits.size() == 0) begin
                    m_state = 1;
                end
            end
            default: begin
                if (start) begin m_state = 1; m_cnt = 0; stream.delete(); end
            end
        endcase
        m_hit = nh;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, exp);
        end
    endtask

    task automatic compare();
        chk("in_ready", int'(in_ready), int'(m_state == 1));
        chk("busy", int'(busy), int'((m_state == 1) || (m_state == 2)));
        chk("done", int'(done), int'(m_state == 3));
        chk("hit", int'(hit), m_hit);
        chk("hit_cnt", int'(hit_cnt), m_cnt);
        if (hit) hits_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_cfg(input logic [6:0] p, input logic [2:0] l, input logic [7:0] t);
        abort = 1'b1; cycle(); abort = 1'b0;
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        in_data = w; in_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            cycle();
            if (m_state == 2) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL handshake_timeout t=%0t", $time);
        end
    endtask

    task automatic finish_word();
        for (int n = 0; (n < 30) && (m_state == 2); n++) cycle();
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        compare();
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        cycle();

        // Full-length pattern inside one word.
        do_cfg(7'b1011010, 3'd7, 8'd0);
        pulse_start(); hits_seen = 0;
        send_word(8'hB4); finish_word();
        chk("t1_hits", hits_seen, 1);
        chk("t1_cnt", int'(hit_cnt), 1);
        chk("t1_ready", int'(in_ready), 1);

        // Short overlapping pattern.
        do_cfg(7'b0000101, 3'd3, 8'd0);
        pulse_start(); hits_seen = 0;
        send_word(8'hAA); finish_word();
`ifdef SEQ_DET_CTRL_NO_OVERLAP_EN
        chk("t2_hits", hits_seen, 2);
        chk("t2_cnt", int'(hit_cnt), 2);
`else
        chk("t2_hits", hits_seen, 3);
        chk("t2_cnt", int'(hit_cnt), 3);
`endif

        // Pattern straddling a word boundary.
        do_cfg(7'b1011010, 3'd7, 8'd0);
        pulse_start(); hits_seen = 0;
        send_word(8'h0B); finish_word();
        send_word(8'h40); finish_word();
        chk("t3_hits", hits_seen, 1);
        chk("t3_cnt", int'(hit_cnt), 1);

        // Threshold reached mid-word.
        do_cfg(7'b0000101, 3'd3, 8'd2);
        pulse_start();
        send_word(8'hAA); finish_word();
        chk("t4_done", int'(done), 1);
        chk("t4_ready", int'(in_ready), 0);
        chk("t4_cnt", int'(hit_cnt), 2);
        pulse_start();
        chk("t4_restart_ready", int'(in_ready), 1);
        chk("t4_restart_cnt", int'(hit_cnt), 0);

        // Abort mid-shift; config writes outside IDLE are ignored.
        do_cfg(7'b0000101, 3'd3, 8'd0);
        pulse_start();
        send_word(8'hAA);
        cfg_we = 1'b1; cfg_pattern = 7'b1111111; cfg_len = 3'd7;
        repeat (4) cycle();
        cfg_we = 1'b0;
        abort = 1'b1; cycle(); abort = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_cnt", int'(hit_cnt), 1);
        pulse_start(); hits_seen = 0;
        send_word(8'hAA); finish_word();
`ifdef SEQ_DET_CTRL_NO_OVERLAP_EN
        chk("t5_pattern_kept", int'(hit_cnt), 2);
`else
        chk("t5_pattern_kept", int'(hit_cnt), 3);
`endif

        // Asynchronous reset mid-shift restores defaults.
        do_cfg(7'b0000101, 3'd3, 8'd0);
        pulse_start();
        send_word(8'hAA);
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_hit", int'(hit), 0);
        chk("t6_rst_cnt", int'(hit_cnt), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ready", int'(in_ready), 0);
        chk("t6_rst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        cycle();
        pulse_start();
        send_word(8'hFF); finish_word();
        send_word(8'hFF); finish_word();
`ifdef SEQ_DET_CTRL_NO_OVERLAP_EN
        chk("t6_default_cfg", int'(hit_cnt), 2);
`else
        chk("t6_default_cfg", int'(hit_cnt), 10);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cfg_we      = ($urandom_range(0, 5) == 0);
            cfg_pattern = 7'($urandom());
            cfg_len     = 3'($urandom());
            cfg_thresh  = 8'($urandom_range(0, 5));
            start       = ($urandom_range(0, 11) == 0);
            abort       = ($urandom_range(0, 79) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = 8'($urandom());
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
